// File: rtl/xadc_seq_bfm_if.sv
// DRP bus bundle for the XADC sequencer model.
// Master drives requests, slave returns drdy/do.
interface xadc_seq_bfm_if;
  logic [15:0] di_in;
  logic [6:0]  daddr_in;
  logic        den_in;
  logic        dwe_in;
  logic        drdy_out;
  logic [15:0] do_out;

  modport master (
    output di_in, daddr_in, den_in, dwe_in,
    input  drdy_out, do_out
  );

  modport slave (
    input  di_in, daddr_in, den_in, dwe_in,
    output drdy_out, do_out
  );
endinterface

// File: rtl/xadc_seq_bfm.sv
// Behavioural XADC model: aux-channel ramp sequencer
// plus a DRP port with fixed response latency.
module xadc_seq_bfm #(
  parameter int NUM_CHANNELS = 2,
  parameter logic [NUM_CHANNELS*5-1:0] CHANNEL_LIST =
    {5'h1C, 5'h14},
  parameter int CONV_CYCLES = 26,
  parameter int DRP_LATENCY = 2,
  parameter logic [11:0] SEED = 12'h800,
  parameter logic [11:0] SEED_SPACING = 12'h100,
  parameter logic [11:0] RAMP_STEP = 12'h001,
  parameter bit REPORT_COLLISION = 1'b1
) (
  input  logic dclk_in,
  input  logic reset_in,
  xadc_seq_bfm_if.slave drp,
  input  logic [NUM_CHANNELS-1:0] vauxp_in,
  input  logic [NUM_CHANNELS-1:0] vauxn_in,
  output logic [4:0] channel_out,
  output logic eoc_out,
  output logic eos_out,
  output logic busy_out,
  output logic alarm_out,
  output logic drp_collision_out
);

  localparam int SW =
    (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [SW-1:0] SLOT_LAST =
    SW'(NUM_CHANNELS - 1);
  localparam logic [15:0] CNT_LAST =
    16'(CONV_CYCLES - 1);
  localparam logic [15:0] LAT_LAST =
    16'(DRP_LATENCY - 1);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16)
  begin : g_bad_num
    $fatal(1, "NUM_CHANNELS out of range");
  end
  if (CONV_CYCLES < 2) begin : g_bad_conv
    $fatal(1, "CONV_CYCLES out of range");
  end
  if (DRP_LATENCY < 1) begin : g_bad_lat
    $fatal(1, "DRP_LATENCY out of range");
  end

  typedef enum logic {S_CONVERT, S_EOC} seq_e;
  typedef enum logic [1:0] {
    D_IDLE, D_WAIT, D_RESP
  } drp_e;

  function automatic logic [11:0] seed_of(int i);
    return SEED + 12'(i) * SEED_SPACING;
  endfunction

  function automatic logic [4:0] ch_of(int i);
    return CHANNEL_LIST[5*i +: 5];
  endfunction

  seq_e seq_q, seq_d;
  logic [15:0] cnt_q, cnt_d;
  logic [SW-1:0] slot_q, slot_d;
  logic busy_q, busy_d;
  logic eoc_q, eoc_d;
  logic eos_q, eos_d;
  logic [4:0] chan_q, chan_d;
  logic [11:0] code_q [NUM_CHANNELS];
  logic [11:0] code_d [NUM_CHANNELS];
  logic upd;

  drp_e drp_q, drp_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic we_q, we_d;
  logic [15:0] snap_q, snap_d;
  logic coll_q, coll_d;
  logic [15:0] cfg_q [3];
  logic [15:0] cfg_d [3];
  logic rd_hit;
  logic [15:0] rd_val;

  logic unused_vaux;
  assign unused_vaux = ^{vauxp_in, vauxn_in};

  // busy_q low means the cycle right after reset;
  // it is spent raising busy, not counting.
  always_comb begin
    seq_d  = seq_q;
    cnt_d  = cnt_q;
    slot_d = slot_q;
    busy_d = busy_q;
    eoc_d  = 1'b0;
    eos_d  = 1'b0;
    chan_d = chan_q;
    upd    = 1'b0;
    case (seq_q)
      S_CONVERT: begin
        if (!busy_q) begin
          busy_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          seq_d  = S_EOC;
          busy_d = 1'b0;
          eoc_d  = 1'b1;
          eos_d  = (slot_q == SLOT_LAST);
          upd    = 1'b1;
          for (int i = 0; i < NUM_CHANNELS; i++)
            if (slot_q == SW'(i)) chan_d = ch_of(i);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_EOC: begin
        seq_d  = S_CONVERT;
        busy_d = 1'b1;
        cnt_d  = '0;
        slot_d = (slot_q == SLOT_LAST) ?
                 '0 : slot_q + SW'(1);
      end
      default: seq_d = S_CONVERT;
    endcase
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      code_d[i] = code_q[i];
      if (upd && slot_q == SW'(i))
        code_d[i] = code_q[i] + RAMP_STEP;
    end
  end

  // Lowest matching slot wins on duplicate channels.
  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!rd_hit &&
          drp.daddr_in == {2'b00, ch_of(i)}) begin
        rd_hit = 1'b1;
        rd_val = {code_q[i], 4'h0};
      end
    end
    for (int j = 0; j < 3; j++) begin
      if (!rd_hit &&
          drp.daddr_in == 7'(64 + j)) begin
        rd_hit = 1'b1;
        rd_val = cfg_q[j];
      end
    end
  end

  always_comb begin
    drp_d  = drp_q;
    wcnt_d = wcnt_q;
    we_d   = we_q;
    snap_d = snap_q;
    coll_d = coll_q;
    for (int j = 0; j < 3; j++) cfg_d[j] = cfg_q[j];
    case (drp_q)
      D_IDLE: begin
        if (drp.den_in) begin
          drp_d  = D_WAIT;
          wcnt_d = '0;
          we_d   = drp.dwe_in;
          snap_d = drp.dwe_in ? 16'h0000 : rd_val;
          for (int j = 0; j < 3; j++)
            if (drp.dwe_in &&
                drp.daddr_in == 7'(64 + j))
              cfg_d[j] = drp.di_in;
        end
      end
      D_WAIT: begin
        if (drp.den_in) coll_d = 1'b1;
        if (wcnt_q == LAT_LAST) drp_d = D_RESP;
        else wcnt_d = wcnt_q + 16'd1;
      end
      D_RESP: begin
        if (drp.den_in) coll_d = 1'b1;
        drp_d = D_IDLE;
      end
      default: drp_d = D_IDLE;
    endcase
  end

  always_ff @(posedge dclk_in) begin
    if (reset_in) begin
      seq_q  <= S_CONVERT;
      cnt_q  <= '0;
      slot_q <= '0;
      busy_q <= 1'b0;
      eoc_q  <= 1'b0;
      eos_q  <= 1'b0;
      chan_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++)
        code_q[i] <= seed_of(i);
      drp_q  <= D_IDLE;
      wcnt_q <= '0;
      we_q   <= 1'b0;
      snap_q <= '0;
      coll_q <= 1'b0;
      for (int j = 0; j < 3; j++) cfg_q[j] <= '0;
    end else begin
      seq_q  <= seq_d;
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      busy_q <= busy_d;
      eoc_q  <= eoc_d;
      eos_q  <= eos_d;
      chan_q <= chan_d;
      for (int i = 0; i < NUM_CHANNELS; i++)
        code_q[i] <= code_d[i];
      drp_q  <= drp_d;
      wcnt_q <= wcnt_d;
      we_q   <= we_d;
      snap_q <= snap_d;
      coll_q <= coll_d;
      for (int j = 0; j < 3; j++) cfg_q[j] <= cfg_d[j];
    end
  end

  always_ff @(posedge dclk_in) begin
    if (REPORT_COLLISION && !reset_in &&
        drp.den_in && drp_q != D_IDLE)
      $error("xadc_seq_bfm: den_in while busy");
  end

  assign drp.drdy_out = (drp_q == D_RESP);
  assign drp.do_out = (drp_q == D_RESP) ?
                      snap_q : 16'h0000;
  assign channel_out = chan_q;
  assign eoc_out = eoc_q;
  assign eos_out = eos_q;
  assign busy_out = busy_q;
  assign alarm_out = 1'b0;
  assign drp_collision_out = coll_q;

endmodule

// File: tb/tb_xadc_seq_bfm.sv
// Directed bench for xadc_seq_bfm: sequencer timing
// table plus hand-written DRP access sequences.
module tb_xadc_seq_bfm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sel = 1'b0;
  logic den = 1'b0;
  logic dwe = 1'b0;
  logic [6:0] addr = '0;
  logic [15:0] di = '0;

  xadc_seq_bfm_if drp0 ();
  xadc_seq_bfm_if drp1 ();

  assign drp0.den_in = den & ~sel;
  assign drp0.dwe_in = dwe;
  assign drp0.daddr_in = addr;
  assign drp0.di_in = di;
  assign drp1.den_in = den & sel;
  assign drp1.dwe_in = dwe;
  assign drp1.daddr_in = addr;
  assign drp1.di_in = di;

  logic [4:0] ch0, ch1;
  logic eoc0, eos0, busy0, alm0, coll0;
  logic eoc1, eos1, busy1, alm1, coll1;

  xadc_seq_bfm #(
    .REPORT_COLLISION(1'b0)
  ) dut (
    .dclk_in(clk), .reset_in(rst), .drp(drp0),
    .vauxp_in(2'b00), .vauxn_in(2'b00),
    .channel_out(ch0), .eoc_out(eoc0),
    .eos_out(eos0), .busy_out(busy0),
    .alarm_out(alm0), .drp_collision_out(coll0)
  );

  xadc_seq_bfm #(
    .NUM_CHANNELS(1),
    .CHANNEL_LIST(5'h14),
    .SEED(12'hFFF),
    .RAMP_STEP(12'h001),
    .REPORT_COLLISION(1'b0)
  ) dut1 (
    .dclk_in(clk), .reset_in(rst), .drp(drp1),
    .vauxp_in(1'b0), .vauxn_in(1'b0),
    .channel_out(ch1), .eoc_out(eoc1),
    .eos_out(eos1), .busy_out(busy1),
    .alarm_out(alm1), .drp_collision_out(coll1)
  );

  logic rdy;
  logic [15:0] dout;
  assign rdy = sel ? drp1.drdy_out : drp0.drdy_out;
  assign dout = sel ? drp1.do_out : drp0.do_out;

  int n_vec = 0;
  int n_bad = 0;
  int e = 0;

  typedef struct {
    int edge_n;
    logic busy;
    logic eoc;
    logic eos;
    logic [4:0] ch;
    logic eoc_b;
    logic eos_b;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h want %h",
               nm, e, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_reset();
    den = 1'b0;
    dwe = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    e = 0;
  endtask

  task automatic access(input logic s,
                        input logic w,
                        input logic [6:0] a,
                        input logic [15:0] d,
                        input logic [15:0] exp,
                        input string nm);
    sel = s;
    den = 1'b1;
    dwe = w;
    addr = a;
    di = d;
    tick();
    den = 1'b0;
    dwe = 1'b0;
    tick();
    chk({nm, " drdy early"}, 16'(rdy), 16'h0);
    tick();
    chk({nm, " drdy"}, 16'(rdy), 16'h1);
    chk({nm, " do"}, dout, exp);
    tick();
    chk({nm, " drdy end"}, 16'(rdy), 16'h0);
    chk({nm, " do idle"}, dout, 16'h0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " busy"}, 16'(busy0), 16'h0);
    chk({nm, " eoc"}, 16'(eoc0), 16'h0);
    chk({nm, " eos"}, 16'(eos0), 16'h0);
    chk({nm, " ch"}, 16'(ch0), 16'h0);
    chk({nm, " alarm"}, 16'(alm0), 16'h0);
    chk({nm, " coll"}, 16'(coll0), 16'h0);
    chk({nm, " drdy"}, 16'(drp0.drdy_out), 16'h0);
    chk({nm, " do"}, drp0.do_out, 16'h0);
    chk({nm, " b busy"}, 16'(busy1), 16'h0);
    chk({nm, " b eoc"}, 16'(eoc1), 16'h0);
  endtask

  initial begin
    vecs[0] = '{1,  1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0};
    vecs[1] = '{26, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0};
    vecs[2] = '{27, 1'b0, 1'b1, 1'b0, 5'h14, 1'b1, 1'b1};
    vecs[3] = '{28, 1'b1, 1'b0, 1'b0, 5'h14, 1'b0, 1'b0};
    vecs[4] = '{53, 1'b1, 1'b0, 1'b0, 5'h14, 1'b0, 1'b0};
    vecs[5] = '{54, 1'b0, 1'b1, 1'b1, 5'h1C, 1'b1, 1'b1};
    vecs[6] = '{55, 1'b1, 1'b0, 1'b0, 5'h1C, 1'b0, 1'b0};
    vecs[7] = '{81, 1'b0, 1'b1, 1'b0, 5'h14, 1'b1, 1'b1};

    do_reset();
    chk_zero("reset");

    foreach (vecs[k]) begin
      while (e < vecs[k].edge_n) tick();
      chk("busy", 16'(busy0), 16'(vecs[k].busy));
      chk("eoc", 16'(eoc0), 16'(vecs[k].eoc));
      chk("eos", 16'(eos0), 16'(vecs[k].eos));
      chk("chan", 16'(ch0), 16'(vecs[k].ch));
      chk("b eoc", 16'(eoc1), 16'(vecs[k].eoc_b));
      chk("b eos", 16'(eos1), 16'(vecs[k].eos_b));
    end

    do_reset();
    while (e < 26) tick();
    access(1'b0, 1'b0, 7'h14, 16'h0, 16'h8000, "rd14 at eoc");
    access(1'b1, 1'b0, 7'h14, 16'h0, 16'h0000, "b rd14 wrap");
    access(1'b0, 1'b0, 7'h14, 16'h0, 16'h8010, "rd14");
    access(1'b0, 1'b0, 7'h1C, 16'h0, 16'h9000, "rd1c");
    access(1'b0, 1'b1, 7'h41, 16'hA5A5, 16'h0, "wr41");
    access(1'b0, 1'b0, 7'h41, 16'h0, 16'hA5A5, "rd41");
    access(1'b0, 1'b0, 7'h03, 16'h0, 16'h0000, "rd03");
    access(1'b0, 1'b0, 7'h40, 16'h0, 16'h0000, "rd40");
    access(1'b0, 1'b0, 7'h1C, 16'h0, 16'h9010, "rd1c 2");
    access(1'b0, 1'b1, 7'h14, 16'h1234, 16'h0, "wr14");
    access(1'b0, 1'b0, 7'h14, 16'h0, 16'h8010, "rd14 ro");

    sel = 1'b0;
    chk("coll pre", 16'(coll0), 16'h0);
    den = 1'b1;
    addr = 7'h42;
    tick();
    tick();
    den = 1'b0;
    chk("coll set", 16'(coll0), 16'h1);
    chk("coll drdy early", 16'(rdy), 16'h0);
    tick();
    chk("coll drdy", 16'(rdy), 16'h1);
    chk("coll do", dout, 16'h0000);
    tick();
    chk("coll drdy end", 16'(rdy), 16'h0);
    tick();
    chk("coll one pulse", 16'(rdy), 16'h0);
    chk("coll sticky", 16'(coll0), 16'h1);

    den = 1'b1;
    addr = 7'h14;
    tick();
    den = 1'b0;
    rst = 1'b1;
    tick();
    chk_zero("abort");
    tick();
    rst = 1'b0;
    e = 0;
    tick();
    chk("abort drdy 1", 16'(rdy), 16'h0);
    tick();
    chk("abort drdy 2", 16'(rdy), 16'h0);
    chk("abort busy", 16'(busy0), 16'h1);
    access(1'b0, 1'b0, 7'h14, 16'h0, 16'h8000, "rd14 seed");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
